// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
//
// Copies a software coefficient register into the shadow bank of a
// double-buffered FIR coefficient RAM. Software writes a pair of taps
// (reg_data) together with a pair index (pair_idx). The loader waits until the
// pair {pair_idx, reg_data} has stopped changing for STABLE_CYC cycles. It then
// writes the even tap and the odd tap to the inactive bank over a
// valid/ready port. When the pair is complete it marks a load as pending, and
// the banks swap at the next FIR frame boundary.
//
// Parameters
//   COEF_W      coefficient width; reg_data is 2*COEF_W bits wide
//   NTAPS       taps per bank (power of two, >= 4)
//   STABLE_CYC  consecutive unchanged cycles required before a value is taken
//   PW          pair-index width, log2(NTAPS)-1
//
// Ports
//   user_clk    single rising-edge clock
//   user_rst_n  asynchronous active-low reset; assertion is immediate and
//               release is synchronised to user_clk
//   reg_data    software register: [31:16] even tap, [15:0] odd tap
//   pair_idx    pair p, which targets taps 2p and 2p+1
//   frame_sync  one-cycle pulse at a FIR frame boundary
//   coef_we     coefficient write valid
//   coef_rdy    bank ready; a tap transfers when coef_we && coef_rdy
//   coef_addr   tap address (valid only while coef_we)
//   coef_data   tap value   (valid only while coef_we)
//   bank_sel    bank the FIR reads; the loader writes the other bank
//   load_done   one-cycle pulse after the odd tap of a pair is accepted
//   load_count  number of completed pair loads, modulo 256
// -----------------------------------------------------------------------------
module fir_coef_loader #(
  parameter int COEF_W     = 16,
  parameter int NTAPS      = 32,
  parameter int STABLE_CYC = 2,
  parameter int PW         = $clog2(NTAPS) - 1
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic [2*COEF_W-1:0] reg_data,
  input  logic [PW-1:0]       pair_idx,
  input  logic                frame_sync,
  output logic                coef_we,
  input  logic                coef_rdy,
  output logic [PW:0]         coef_addr,
  output logic [COEF_W-1:0]   coef_data,
  output logic                bank_sel,
  output logic                load_done,
  output logic [7:0]          load_count
);

  // Width of the stability counter. It only has to reach STABLE_CYC-1.
  localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WR_EVEN,
    WR_ODD
  } state_t;

  // The monitored value: the pair index together with both taps.
  typedef struct packed {
    logic [PW-1:0]       idx;
    logic [2*COEF_W-1:0] data;
  } key_t;

  // ---------------------------------------------------------------------------
  // Reset synchroniser. Assertion clears both flops at once, so the internal
  // reset falls in the same instant as user_rst_n. Release ripples through
  // the two flops, so the FSM never leaves reset on a partial clock edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Loader state
  // ---------------------------------------------------------------------------
  key_t            key;
  key_t            last_key, last_key_nxt;   // last value written to the bank
  key_t            cand, cand_nxt;           // value currently settling
  key_t            lat, lat_nxt;             // value being written
  logic [CW-1:0]   stab_cnt, stab_cnt_nxt;
  state_t          state, state_nxt;
  logic            done_nxt;
  logic            pending;
  logic            swap;

  assign key = '{idx: pair_idx, data: reg_data};

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples the values that were present before the clock edge.
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_key <= '0;
      cand     <= '0;
      lat      <= '0;
      stab_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_key <= last_key_nxt;
      cand     <= cand_nxt;
      lat      <= lat_nxt;
      stab_cnt <= stab_cnt_nxt;
    end
  end

  // Next-state and output decode. The write port is driven straight from the
  // state and the latched pair. Its address and data therefore cannot move
  // while a tap waits for coef_rdy, whatever software does to reg_data.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt    = state;
    last_key_nxt = last_key;
    cand_nxt     = cand;
    lat_nxt      = lat;
    stab_cnt_nxt = stab_cnt;
    done_nxt     = 1'b0;
    coef_we      = 1'b0;
    coef_addr    = '0;
    coef_data    = '0;

    unique case (state)
      IDLE: begin
        if (key != last_key) begin
          state_nxt    = SETTLE;
          cand_nxt     = key;
          stab_cnt_nxt = '0;
        end
      end

      SETTLE: begin
        if (key != cand) begin
          // The value moved again, so restart the stability window.
          cand_nxt     = key;
          stab_cnt_nxt = '0;
        end else if (stab_cnt == STAB_LAST) begin
          lat_nxt      = cand;
          last_key_nxt = cand;
          state_nxt    = WR_EVEN;
        end else begin
          stab_cnt_nxt = stab_cnt + 1'b1;
        end
      end

      WR_EVEN: begin
        coef_we   = 1'b1;
        coef_addr = {lat.idx, 1'b0};
        coef_data = lat.data[2*COEF_W-1:COEF_W];
        if (coef_rdy) state_nxt = WR_ODD;
      end

      WR_ODD: begin
        coef_we   = 1'b1;
        coef_addr = {lat.idx, 1'b1};
        coef_data = lat.data[COEF_W-1:0];
        if (coef_rdy) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Completion pulse, load counter and bank swap. A load that completes in
  // the same cycle as frame_sync swaps at once and never becomes pending.
  // ---------------------------------------------------------------------------
  assign swap = frame_sync && (pending || load_done);

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      load_done  <= 1'b0;
      load_count <= 8'd0;
      pending    <= 1'b0;
      bank_sel   <= 1'b0;
    end else begin
      load_done <= done_nxt;
      if (done_nxt) load_count <= load_count + 8'd1;

      if (swap) begin
        bank_sel <= ~bank_sel;
        pending  <= 1'b0;
      end else if (load_done) begin
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_loader
//
// Self-checking bench for fir_coef_loader. A reference model sits at the level
// of whole transactions:
//   - every committed pair adds two expected tap writes to a queue, at
//     addresses 2p and 2p+1;
//   - the load counter is a modulo-256 count of completions;
//   - the bank selector flips on a frame pulse when at least one completion
//     has occurred since the last flip.
// A negedge monitor pops the queue on every accepted write.
// -----------------------------------------------------------------------------
module tb_fir_coef_loader;

  localparam int COEF_W     = 16;
  localparam int NTAPS      = 32;
  localparam int STABLE_CYC = 2;
  localparam int PW         = $clog2(NTAPS) - 1;

  logic                user_clk;
  logic                user_rst_n;
  logic [2*COEF_W-1:0] reg_data;
  logic [PW-1:0]       pair_idx;
  logic                frame_sync;
  logic                coef_we;
  logic                coef_rdy;
  logic [PW:0]         coef_addr;
  logic [COEF_W-1:0]   coef_data;
  logic                bank_sel;
  logic                load_done;
  logic [7:0]          load_count;

  fir_coef_loader #(
    .COEF_W     (COEF_W),
    .NTAPS      (NTAPS),
    .STABLE_CYC (STABLE_CYC),
    .PW         (PW)
  ) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .reg_data   (reg_data),
    .pair_idx   (pair_idx),
    .frame_sync (frame_sync),
    .coef_we    (coef_we),
    .coef_rdy   (coef_rdy),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .bank_sel   (bank_sel),
    .load_done  (load_done),
    .load_count (load_count)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];        // {addr[15:0], data[15:0]} in expected order
  logic [7:0]  exp_count = 8'd0;
  logic        exp_bank  = 1'b0;
  int          unswapped = 0;   // completions since the last bank flip
  bit          rand_rdy  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge and outputs are sampled
  // there or on the falling edge, well away from the active edge.
  task automatic step();
    @(posedge user_clk);
    #2;
    if (rand_rdy) coef_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic push_pair(input int idx, input logic [31:0] d);
    exp_q.push_back({16'(idx * 2), d[31:16]});
    exp_q.push_back({16'(idx * 2 + 1), d[15:0]});
  endtask

  task automatic set_key(input int idx, input logic [31:0] d);
    pair_idx = PW'(idx);
    reg_data = d;
  endtask

  task automatic note_load();
    exp_count = exp_count + 8'd1;
    unswapped++;
    check("load_count", load_count, exp_count);
  endtask

  task automatic wait_load_done(input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (load_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("load_done_timeout", load_done, 1'b1);
    else      note_load();
  endtask

  task automatic pulse_frame();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    if (unswapped != 0) begin
      exp_bank  = ~exp_bank;
      unswapped = 0;
    end
    check("bank_sel", bank_sel, exp_bank);
  endtask

  task automatic model_reset();
    exp_count = 8'd0;
    exp_bank  = 1'b0;
    unswapped = 0;
  endtask

  // Scoreboard on accepted writes.
  always @(negedge user_clk) begin
    if (coef_we && coef_rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", {coef_addr, coef_data}, 64'hDEAD_0000_0000_0000);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", coef_addr, e[31:16]);
        check("wr_data", coef_data, e[15:0]);
      end
    end
  end

  initial begin
    int          n;
    logic [31:0] a0, d0;
    int          last_idx;
    logic [31:0] last_data;

    user_rst_n = 1'b0;
    frame_sync = 1'b0;
    coef_rdy   = 1'b1;
    set_key(3, 32'h1234_5678);
    repeat (3) step();

    // Reset state.
    check("rst_we",    coef_we,    1'b0);
    check("rst_addr",  coef_addr,  0);
    check("rst_data",  coef_data,  0);
    check("rst_bank",  bank_sel,   1'b0);
    check("rst_done",  load_done,  1'b0);
    check("rst_count", load_count, 0);

    // First load straight out of reset.
    push_pair(3, 32'h1234_5678);
    user_rst_n = 1'b1;
    wait_load_done(30);
    check("rel_queue_empty", exp_q.size(), 0);
    step();
    check("done_is_pulse", load_done, 1'b0);

    // Latency from a key change, then a swap in the load_done cycle.
    set_key(5, 32'h0BAD_F00D);
    push_pair(5, 32'h0BAD_F00D);
    n = 0;
    while (!coef_we && n < 20) begin
      step();
      n++;
    end
    check("latency_first_we", n, STABLE_CYC + 1);
    n = 0;
    while (!load_done && n < 20) begin
      step();
      n++;
    end
    check("latency_done", n, 2);
    if (load_done) note_load();
    pulse_frame();                       // load_done and frame_sync together
    check("swap_to_1", bank_sel, 1'b1);
    repeat (3) step();
    pulse_frame();                       // nothing pending: no flip
    check("no_swap_hold_1", bank_sel, 1'b1);

    // Glitching register: only the settled value is written.
    set_key(5, 32'hAAAA_0000);
    step();
    set_key(5, 32'hBBBB_0000);
    push_pair(5, 32'hBBBB_0000);
    wait_load_done(30);
    check("glitch_queue_empty", exp_q.size(), 0);

    // Back-pressure on the even tap, with a register change in flight.
    coef_rdy = 1'b0;
    set_key(9, 32'hC0DE_1234);
    push_pair(9, 32'hC0DE_1234);
    n = 0;
    while (!coef_we && n < 20) begin
      step();
      n++;
    end
    check("stall_we_seen", coef_we, 1'b1);
    a0 = 32'(coef_addr);
    d0 = 32'(coef_data);
    check("stall_even_addr", coef_addr, 18);
    check("stall_even_data", coef_data, 16'hC0DE);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        set_key(2, 32'h5555_AAAA);
        push_pair(2, 32'h5555_AAAA);
      end
      step();
      check("stall_hold_we",   coef_we,   1'b1);
      check("stall_hold_addr", coef_addr, a0);
      check("stall_hold_data", coef_data, d0);
    end
    coef_rdy = 1'b1;
    step();
    check("stall_odd_addr", coef_addr, 19);
    check("stall_odd_data", coef_data, 16'h1234);
    wait_load_done(30);
    wait_load_done(30);                  // the change made during the stall
    check("stall_queue_empty", exp_q.size(), 0);

    // Reset while the odd tap is on the port.
    set_key(7, 32'h600D_CAFE);
    push_pair(7, 32'h600D_CAFE);
    for (int i = 0; i < 20; i++) begin
      step();
      if (coef_we && coef_addr[0]) break;
    end
    check("odd_reached", coef_addr[0], 1'b1);
    user_rst_n = 1'b0;
    #1;
    check("midrst_we",    coef_we,    1'b0);
    check("midrst_count", load_count, 0);
    check("midrst_done",  load_done,  1'b0);
    check("abandoned_entries", exp_q.size(), 1);
    exp_q.delete();
    model_reset();
    repeat (2) step();
    user_rst_n = 1'b1;
    push_pair(7, 32'h600D_CAFE);
    wait_load_done(30);
    check("reload_queue_empty", exp_q.size(), 0);

    // Randomised loads with a random ready, glitches and frame pulses.
    last_idx  = 7;
    last_data = 32'h600D_CAFE;
    rand_rdy  = 1'b1;
    for (int it = 0; it < 24; it++) begin
      int          idx;
      logic [31:0] d, g;
      idx = int'($urandom_range(0, (1 << PW) - 1));
      d   = $urandom;
      if (idx == last_idx && d == last_data) d = d ^ 32'h1;
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom;
        if (g == d) g = g ^ 32'h8000_0000;
        set_key(idx, g);
        step();
      end
      set_key(idx, d);
      push_pair(idx, d);
      last_idx  = idx;
      last_data = d;
      wait_load_done(200);
      if ($urandom_range(0, 1) == 1) pulse_frame();
      if ($urandom_range(0, 2) == 0) begin
        repeat (2) step();
        pulse_frame();
      end
    end
    check("rand_queue_empty", exp_q.size(), 0);
    rand_rdy = 1'b0;
    coef_rdy = 1'b1;

    // Counter wrap after 256 loads from a fresh reset with a zero key.
    user_rst_n = 1'b0;
    set_key(0, 32'h0);
    repeat (2) step();
    model_reset();
    user_rst_n = 1'b1;
    repeat (4) step();
    check("zero_key_no_load", load_count, 0);
    for (int i = 1; i <= 256; i++) begin
      logic [31:0] d;
      d = {16'(i + 16'h0100), ~16'(i)};
      set_key(i % 16, d);
      push_pair(i % 16, d);
      wait_load_done(30);
      if (i == 255) check("count_255", load_count, 8'd255);
    end
    check("count_wrap", load_count, 0);
    check("wrap_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 SHALL have parameter COEF_W, default 16: coefficient width; 2*COEF_W = 32.
REQ-002 SHALL have parameter NTAPS, default 32: taps in the coefficient bank; a power of 2, at least 4.
REQ-003 SHALL have parameter STABLE_CYC, default 2: consecutive unchanged cycles required before a register value is accepted.
REQ-004 SHALL have parameter PW, default log2(NTAPS)-1: pair-index width.
REQ-005 SHALL have port user_clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port user_rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port reg_data, input, 32: software coefficient register. [31:16] is the even tap; [15:0] is the odd tap.
REQ-008 SHALL have port pair_idx, input, PW: software pair index p, targeting taps 2p and 2p+1.
REQ-009 SHALL have port frame_sync, input, 1: one-cycle pulse marking a FIR frame boundary.
REQ-010 SHALL have port coef_we, output, 1: coefficient write valid.
REQ-011 SHALL have port coef_rdy, input, 1: bank accepts the write; a transfer occurs when coef_we && coef_rdy.
REQ-012 SHALL have port coef_addr, output, PW+1: tap address.
REQ-013 SHALL have port coef_data, output, COEF_W: tap value.
REQ-014 SHALL have port bank_sel, output, 1: active coefficient bank; the FIR reads bank_sel and the loader writes !bank_sel.
REQ-015 SHALL have port load_done, output, 1: one-cycle pulse after both taps of a pair are written.
REQ-016 SHALL have port load_count, output, 8: count of completed pair loads; wraps 255 -> 0.

Function
REQ-017 SHALL treat key = {pair_idx, reg_data} as the monitored value, held in last_key.
REQ-018 SHALL implement the FSM states IDLE, SETTLE, WR_EVEN and WR_ODD.
REQ-019 In IDLE, key != last_key SHALL cause a transition to SETTLE, load cand <= key and clear stab_cnt to 0.
REQ-020 In SETTLE:
- key != cand SHALL reload cand and clear stab_cnt (restart).
- Otherwise stab_cnt SHALL increment.
- When stab_cnt reaches STABLE_CYC-1 with key == cand, the block SHALL latch lat <= cand and last_key <= cand, then go to WR_EVEN.
REQ-021 In WR_EVEN, the block SHALL drive coef_we=1, coef_addr={lat.idx,1'b0} and coef_data=lat.data[31:16], and hold them stable until coef_rdy.
- On transfer, it SHALL go to WR_ODD.
REQ-022 In WR_ODD, the block SHALL drive coef_we=1, coef_addr={lat.idx,1'b1} and coef_data=lat.data[15:0], and hold them until coef_rdy.
- On transfer, it SHALL go to IDLE, pulse load_done in the following cycle and increment load_count.
REQ-023 Changes to key during WR_EVEN/WR_ODD SHALL NOT alter outputs in flight; they are detected in IDLE by the last_key compare.
REQ-024 coef_we SHALL be 0 in IDLE and SETTLE; coef_addr and coef_data SHALL be don't-care while coef_we=0.
REQ-025 The pending flag SHALL be set by load_done and cleared by a swap.
REQ-026 bank_sel SHALL toggle on frame_sync when pending=1 or load_done=1 in the same cycle, and the swap SHALL clear pending.
- frame_sync with no pending load SHALL leave bank_sel unchanged.
REQ-027 Minimum latency, from a key change to the first coef_we, SHALL be STABLE_CYC+1 cycles; with coef_rdy held at 1, the pair SHALL complete 2 cycles later.
REQ-028 With coef_rdy held at 0, the FSM SHALL wait indefinitely; there is no timeout.

Reset
REQ-029 While user_rst_n=0, the following SHALL hold, applied asynchronously:
- FSM=IDLE.
- coef_we=0, coef_addr=0, coef_data=0.
- bank_sel=0, load_done=0, load_count=0, pending=0.
- last_key=0, cand=0, stab_cnt=0.
REQ-030 Reset asserted mid-write SHALL abandon the pair with no load_done.
- After release, a nonzero key SHALL trigger a fresh load, because last_key=0.
REQ-031 Deassertion SHALL be synchronised to user_clk before reaching the FSM.

Verification
REQ-032 SHALL cover: reset release with reg_data=0x12345678, pair_idx=3, coef_rdy=1 -> writes addr 6 data 0x1234, then addr 7 data 0x5678, load_done=1, load_count=1.
REQ-033 SHALL cover: reg_data toggles 0xAAAA0000 -> 0xBBBB0000 on consecutive cycles, then holds -> exactly one pair is written, with data 0xBBBB then 0x0000.
REQ-034 SHALL cover: coef_rdy=0 for 5 cycles during WR_EVEN -> coef_addr and coef_data hold; the write completes 1 cycle after coef_rdy=1.
REQ-035 SHALL cover: load_done and frame_sync in the same cycle -> bank_sel toggles 0->1 and pending stays 0; a later frame_sync -> bank_sel stays 1.
REQ-036 SHALL cover: user_rst_n asserted during WR_ODD -> coef_we=0 immediately and load_count=0; after release the same key is reloaded.
REQ-037 SHALL cover: 256 distinct loads -> load_count wraps to 0.
